// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: bridges single-cycle pipeline loads/stores onto a multicycle memory port.
// Latency: load data in RdD three cycles after the request, plus memory stall and wait cycles.
// Backpressure: stall holds the pipeline through REQ/WAIT; mem_stall holds the strobe in REQ.
module mem_req_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluResult,
  input  logic [15:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        dump,
  output logic [15:0] RdD,
  output logic        stall,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_dump,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall,
  input  logic        mem_done
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        nextState;
  logic          opWrite;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] waitCntInc;
  logic          relHold;
  logic          pipeReq;
  logic          accept;
  logic          unaligned;
  logic          timeoutHit;

  // The aborted request is still sitting on the pipeline inputs in the cycle right
  // after a timeout; relHold masks it so the pipeline is released instead of re-issuing.
  assign pipeReq    = (memRead | memWrite) & ~relHold;
  assign accept     = (state == IDLE) & pipeReq & ~aluResult[0];
  assign unaligned  = (state == IDLE) & pipeReq & aluResult[0];
  assign waitCntInc = (waitCnt == TO_CNT) ? waitCnt : waitCnt + 1'b1;
  assign timeoutHit = (state == WAIT) & ~mem_done & (waitCntInc == TO_CNT);
  assign mem_dump   = dump;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic; mem_done wins over a timeout on the same cycle
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (accept) nextState = REQ;
      REQ:  if (!mem_stall) nextState = WAIT;
      WAIT: begin
        if (mem_done)        nextState = DONE;
        else if (timeoutHit) nextState = IDLE;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs: strobes only in REQ and never during reset; stall covers the whole request
  always_comb begin
    stall  = accept | (state == REQ) | (state == WAIT);
    mem_rd = (state == REQ) & ~opWrite & ~rst;
    mem_wr = (state == REQ) &  opWrite & ~rst;
  end

  // Request latch, load-data capture, sticky error, wait counter and release hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_data_in <= '0;
      opWrite     <= 1'b0;
      RdD         <= '0;
      err         <= 1'b0;
      waitCnt     <= '0;
      relHold     <= 1'b0;
    end else begin
      relHold <= timeoutHit;
      if (accept) begin
        mem_addr    <= aluResult;
        mem_data_in <= writeData;
        opWrite     <= memWrite;
      end
      if (unaligned || timeoutHit) err <= 1'b1;
      if ((state == WAIT) && mem_done && !opWrite) RdD <= mem_data_out;
      if ((state == REQ) && !mem_stall) waitCnt <= '0;
      else if (state == WAIT)           waitCnt <= waitCntInc;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: directed table of transactions, reset corner sequences,
// and randomized transactions checked against a transaction-level expectation model.
module tb_mem_req_ctrl;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] aluResult, writeData, mem_data_out;
  logic        memRead, memWrite, dump, mem_stall, mem_done;
  logic [15:0] RdD, mem_addr, mem_data_in;
  logic        stall, err, mem_rd, mem_wr, mem_dump;

  mem_req_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .aluResult(aluResult), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .dump(dump), .RdD(RdD),
    .stall(stall), .err(err), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dump(mem_dump),
    .mem_data_out(mem_data_out), .mem_stall(mem_stall), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wd;
    int          nStall;     // cycles mem_stall is high while the strobe is up
    int          doneDelay;  // WAIT cycles before mem_done (>= TO means it never comes in time)
    logic [15:0] rdat;
    logic        gap;        // idle cycle after the transaction
    int          expLat;     // cycles from request until stall first low
    int          expStrobes;
    logic [15:0] expRd;
    logic        expE;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expRdD = '0;
  logic        expErr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                                 input int nStall, input int doneDelay, input logic [15:0] rdat,
                                 input logic gap, input int expLat, input int expStrobes,
                                 input logic [15:0] expRd, input logic expE);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wd = wd; v.nStall = nStall; v.doneDelay = doneDelay;
    v.rdat = rdat; v.gap = gap; v.expLat = expLat; v.expStrobes = expStrobes;
    v.expRd = expRd; v.expE = expE;
    return v;
  endfunction

  // Transaction-level expectations from the controller's rules
  function automatic vec_t model(input vec_t v, input logic [15:0] rdPrev, input logic ePrev);
    vec_t r;
    r = v;
    r.expRd = rdPrev;
    r.expE  = ePrev;
    if (v.addr[0]) begin
      r.expLat = 0; r.expStrobes = 0; r.expE = 1'b1;
    end else begin
      r.expStrobes = v.nStall + 1;
      if (v.doneDelay < TO) begin
        r.expLat = 3 + v.nStall + v.doneDelay;
        if (!v.wr) r.expRd = v.rdat;
      end else begin
        r.expLat = 2 + v.nStall + TO;
        r.expE   = 1'b1;
      end
    end
    return r;
  endfunction

  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic runOp(input vec_t v, input string tag);
    int          k, acc, strobes, lat;
    logic        badStrobe, eS;
    logic [15:0] rdS;
    k = 0; acc = -1; strobes = 0; lat = -1; badStrobe = 0; eS = 0; rdS = '0;
    memRead = ~v.wr; memWrite = v.wr; aluResult = v.addr; writeData = v.wd;
    while (lat < 0 && k < 60) begin
      mem_stall    = (strobes < v.nStall);
      mem_done     = (acc >= 0) && (k == acc + 1 + v.doneDelay);
      mem_data_out = mem_done ? v.rdat : (16'h0BAD ^ 16'(k));
      @(negedge clk);
      if (mem_rd || mem_wr) begin
        strobes++;
        if (mem_rd === v.wr || mem_wr !== v.wr || mem_addr !== v.addr ||
            (v.wr && mem_data_in !== v.wd)) badStrobe = 1'b1;
        if (!mem_stall) acc = k;
      end
      if (!stall) begin
        lat = k; rdS = RdD; eS = err;
      end
      @(posedge clk); #1;
      k++;
    end
    mem_stall = 1'b0; mem_done = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    if (v.addr[0] || v.gap) begin
      @(negedge clk);
      eS = err;
      if (stall || mem_rd || mem_wr) badStrobe = 1'b1;
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, lat, v.expLat);
    chk({tag, " strobes"}, strobes, v.expStrobes);
    chk({tag, " strobe_ok"}, {31'd0, badStrobe}, 32'd0);
    chk({tag, " RdD"}, rdS, v.expRd);
    chk({tag, " err"}, eS, v.expE);
  endtask

  vec_t tbl[6];

  initial begin
    // lat = 3 + nStall + doneDelay for completions; 2 + nStall + TO for timeouts
    tbl[0] = mkVec(0, 16'h0010, 16'h0000, 0, 1,  16'hBEEF, 0, 4,  1, 16'hBEEF, 0);
    tbl[1] = mkVec(1, 16'h0020, 16'h1234, 3, 0,  16'h7777, 1, 6,  4, 16'hBEEF, 0);
    tbl[2] = mkVec(0, 16'h0040, 16'h0000, 0, 14, 16'hCAFE, 0, 17, 1, 16'hCAFE, 0);
    tbl[3] = mkVec(0, 16'h0050, 16'h0000, 1, 15, 16'h9999, 1, 18, 2, 16'hCAFE, 1);
    tbl[4] = mkVec(0, 16'h0011, 16'h0000, 0, 0,  16'h4444, 1, 0,  0, 16'hCAFE, 1);
    tbl[5] = mkVec(1, 16'h0060, 16'h5555, 0, 0,  16'h3333, 0, 3,  1, 16'hCAFE, 1);

    rst = 1'b1; aluResult = '0; writeData = '0; memRead = 0; memWrite = 0; dump = 0;
    mem_data_out = '0; mem_stall = 0; mem_done = 0;
    #12;
    chk("reset RdD", RdD, 16'h0);
    chk("reset err", err, 1'b0);
    chk("reset mem_addr", mem_addr, 16'h0);
    chk("reset mem_data_in", mem_data_in, 16'h0);
    chk("reset strobes", {mem_rd, mem_wr}, 2'b00);
    chk("reset stall", stall, 1'b0);
    dump = 1'b1; #1;
    chk("dump high", mem_dump, 1'b1);
    dump = 1'b0; #1;
    chk("dump low", mem_dump, 1'b0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      runOp(tbl[i], $sformatf("vec%0d", i));
      expRdD = tbl[i].expRd; expErr = tbl[i].expE;
    end

    // Reset while in WAIT, then a late mem_done must be ignored
    memRead = 1'b1; aluResult = 16'h0070; mem_stall = 1'b0; mem_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1; #1;
    chk("rstwait RdD", RdD, 16'h0);
    chk("rstwait err", err, 1'b0);
    chk("rstwait strobes", {mem_rd, mem_wr}, 2'b00);
    memRead = 1'b0; mem_done = 1'b1; mem_data_out = 16'h1111;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rstwait late done strobes", {mem_rd, mem_wr}, 2'b00);
    @(posedge clk); #1; mem_done = 1'b0;
    @(negedge clk);
    chk("rstwait late done RdD", RdD, 16'h0);
    chk("rstwait stall", stall, 1'b0);
    expRdD = '0; expErr = 1'b0;

    // Request held across reset release is taken on the first edge
    @(posedge clk); #1;
    rst = 1'b1; memRead = 1'b1; aluResult = 16'h0080;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rstrel idle stall", stall, 1'b1);
    chk("rstrel idle mem_rd", mem_rd, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstrel mem_rd", mem_rd, 1'b1);
    chk("rstrel mem_addr", mem_addr, 16'h0080);
    mem_stall = 1'b1; rst = 1'b1; memRead = 1'b0; #1;
    chk("rst strobe low", {mem_rd, mem_wr}, 2'b00);
    @(posedge clk); #1; rst = 1'b0; mem_stall = 1'b0;

    for (int i = 0; i < 40; i++) begin
      vec_t        v;
      logic [15:0] a;
      a = 16'($urandom);
      a[0] = ($urandom_range(0, 7) == 0);
      v.wr = 1'($urandom_range(0, 1));
      v.addr = a;
      v.wd = 16'($urandom);
      v.nStall = $urandom_range(0, 3);
      v.doneDelay = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 1)
                                                : $urandom_range(0, 4);
      v.rdat = 16'($urandom);
      v.gap = 1'($urandom_range(0, 1));
      v = model(v, expRdD, expErr);
      runOp(v, $sformatf("rnd%0d", i));
      expRdD = v.expRd; expErr = v.expE;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_req_ctrl.md
MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum WAIT-state cycles before the controller aborts a request.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 aluResult  input  16  pipeline effective address.
REQ-005 writeData  input  16  pipeline store data.
REQ-006 memRead  input  1  pipeline load request.
REQ-007 memWrite  input  1  pipeline store request; memRead and memWrite both high is treated as a write.
REQ-008 dump  input  1  dump request, forwarded to mem_dump.
REQ-009 RdD  output  16  registered load data returned to the pipeline.
REQ-010 stall  output  1  pipeline hold; while high the pipeline holds all inputs stable.
REQ-011 err  output  1  sticky error flag.
REQ-012 mem_addr  output  16  registered address to the multicycle memory.
REQ-013 mem_data_in  output  16  registered store data to memory.
REQ-014 mem_rd  output  1  memory read strobe.
REQ-015 mem_wr  output  1  memory write strobe.
REQ-016 mem_dump  output  1  combinational copy of dump.
REQ-017 mem_data_out  input  16  memory read data, valid when mem_done is high.
REQ-018 mem_stall  input  1  memory busy; a strobe raised while mem_stall is high is not accepted.
REQ-019 mem_done  input  1  single-cycle completion pulse from memory.

Function
REQ-020 FSM states: IDLE, REQ, WAIT, DONE; 2-bit encoding; reset state IDLE.
REQ-021 IDLE: on memRead|memWrite with aluResult[0]=0, latch address, data and op into mem_addr, mem_data_in and an op register, then go to REQ.
REQ-022 IDLE: on memRead|memWrite with aluResult[0]=1 (unaligned), set err, issue no strobe, stay IDLE.
REQ-023 REQ: drive mem_rd or mem_wr (per latched op, never both); if mem_stall=0, the request is accepted, go to WAIT and clear the cycle counter.
REQ-024 REQ: if mem_stall=1, stay in REQ and hold the strobe, address and data unchanged.
REQ-025 WAIT: strobes low; counter increments each cycle; on mem_done go to DONE; for a read, capture mem_data_out into RdD on the same edge.
REQ-026 WAIT: a write leaves RdD unchanged.
REQ-027 WAIT: if the counter reaches TIMEOUT without mem_done, set err, leave RdD unchanged and go to IDLE.
REQ-028 WAIT timeout: after a timeout, stall deasserts so the pipeline is released.
REQ-029 mem_done in WAIT on the same cycle as the timeout count takes priority: normal completion to DONE, err not set.
REQ-030 mem_done received outside WAIT is ignored.
REQ-031 DONE: lasts exactly one cycle, stall=0, RdD valid; pipeline inputs are ignored this cycle; next state IDLE.
REQ-032 stall = (IDLE & (memRead|memWrite) & ~aluResult[0]) | REQ | WAIT; combinational.
REQ-033 Load latency to RdD valid = 3 + (cycles mem_stall held in REQ) + (WAIT cycles until mem_done).
REQ-034 err, once set, stays high until rst; it does not block later requests.
REQ-035 Counter width is sufficient for TIMEOUT; counter saturates and never wraps.

Reset
REQ-036 rst high forces, asynchronously: state IDLE, RdD=0, mem_addr=0, mem_data_in=0, err=0, counter=0.
REQ-037 While rst is high, mem_rd=0 and mem_wr=0.
REQ-038 Reset mid-request abandons the request with no further strobe.
REQ-039 After rst is released, a request held on the pipeline inputs is accepted from IDLE on the first clock edge.

Verification
REQ-040 Load: aluResult=0x0010, memRead=1, mem_stall=0, mem_done 2 cycles after strobe with mem_data_out=0xBEEF -> one mem_rd pulse with mem_addr=0x0010, RdD=0xBEEF in DONE, stall low exactly in DONE.
REQ-041 Store with stall: memWrite=1, aluResult=0x0020, writeData=0x1234, mem_stall=1 for 3 cycles -> mem_wr held 4 cycles with stable addr/data, then WAIT; RdD unchanged.
REQ-042 Unaligned: memRead=1, aluResult=0x0011 -> err=1 next cycle, no strobe, stall=0.
REQ-043 Timeout: memRead=1, mem_done never asserted -> err=1 after TIMEOUT WAIT cycles, state IDLE, RdD unchanged.
REQ-044 Reset in WAIT: assert rst mid-WAIT -> RdD=0, err=0, strobes low immediately; a later mem_done is ignored.
REQ-045 Back-to-back: load then store on consecutive instructions -> second request starts from IDLE after DONE, no strobe issued in DONE, each op strobed exactly once.
